// File: rtl/memory_burst_master.sv
// Avalon-MM burst master: turns core read/write burst requests into avm_* bursts.
// Optional watchdog abort is enabled by defining MEM_MASTER_TIMEOUT_EN.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready for a request; done/err pulses are presented here
// RD_CMD  | read command on the bus, held until waitrequest drops
// RD_DATA | collecting readdatavalid beats up to the latched length
// WR_DATA | streaming write beats; address/burstcount held for the burst
module memory_burst_master #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8,
    parameter int TMO_CYC   = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] avm_addr,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    output logic [3:0]        avm_burstcount,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_CMD  = 2'd1;
    localparam logic [1:0] RD_DATA = 2'd2;
    localparam logic [1:0] WR_DATA = 2'd3;

    localparam logic [3:0] MAX_LEN = 4'(MAX_BURST);
    localparam logic [7:0] TMO_LIM = 8'(TMO_CYC);

    generate
        if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
            $error("memory_burst_master: MAX_BURST must be 1..15");
        end
        if (TMO_CYC < 1 || TMO_CYC > 255) begin : g_bad_tmo
            $error("memory_burst_master: TMO_CYC must be 1..255");
        end
    endgenerate

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        len_q;
    logic [3:0]        beat_cnt;
    logic              done_q;

    logic [3:0]        len_eff;
    logic              busy;
    logic              rd_beat;
    logic              wr_beat;
    logic              last_beat;
    logic              tmo_hit;

    always_comb begin
        len_eff = req_len;
        if (req_len == 4'd0) begin
            len_eff = 4'd1;
        end else if (req_len > MAX_LEN) begin
            len_eff = MAX_LEN;
        end
    end

    assign busy      = (state != IDLE);
    assign rd_beat   = (state == RD_DATA) && avm_readdatavalid;
    assign wr_beat   = (state == WR_DATA) && wr_valid && !avm_waitrequest;
    assign last_beat = (beat_cnt == (len_q - 4'd1));

    assign req_ready      = (state == IDLE);
    assign avm_read       = (state == RD_CMD);
    assign avm_write      = (state == WR_DATA) && wr_valid;
    assign avm_addr       = busy ? addr_q : '0;
    assign avm_burstcount = busy ? len_q : 4'd0;
    assign avm_writedata  = avm_write ? wr_data : '0;
    assign wr_ready       = wr_beat;
    // Read data is a zero-latency pass-through; zeroed outside a valid beat.
    assign rd_valid       = rd_beat;
    assign rd_data        = rd_beat ? avm_readdata : '0;
    assign rd_last        = rd_beat && last_beat;
    assign done           = done_q;

`ifdef MEM_MASTER_TIMEOUT_EN
    logic [7:0] wdog;
    logic       err_q;
    logic       progress;

    assign progress = ((state == RD_CMD) && !avm_waitrequest) || rd_beat || wr_beat;
    assign tmo_hit  = busy && !progress && (wdog == (TMO_LIM - 8'd1));
    assign err      = err_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wdog  <= 8'd0;
            err_q <= 1'b0;
        end else begin
            err_q <= tmo_hit;
            if (!busy || progress || tmo_hit) begin
                wdog <= 8'd0;
            end else begin
                wdog <= wdog + 8'd1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            len_q    <= 4'd0;
            beat_cnt <= 4'd0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        len_q    <= len_eff;
                        beat_cnt <= 4'd0;
                        state    <= req_write ? WR_DATA : RD_CMD;
                    end
                end
                RD_CMD: begin
                    if (!avm_waitrequest) begin
                        state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rd_beat) begin
                        if (last_beat) begin
                            state    <= IDLE;
                            done_q   <= 1'b1;
                            beat_cnt <= 4'd0;
                        end else begin
                            beat_cnt <= beat_cnt + 4'd1;
                        end
                    end
                end
                WR_DATA: begin
                    if (wr_beat) begin
                        if (last_beat) begin
                            state    <= IDLE;
                            done_q   <= 1'b1;
                            beat_cnt <= 4'd0;
                        end else begin
                            beat_cnt <= beat_cnt + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // A timeout only fires on a no-progress cycle, so it never races done.
            if (tmo_hit) begin
                state    <= IDLE;
                beat_cnt <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_memory_burst_master.sv
// Directed self-checking bench for memory_burst_master (default MAX_BURST=8, TMO_CYC=255).
// Build with MEM_MASTER_TIMEOUT_EN defined to exercise the watchdog abort path.
module tb_memory_burst_master;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [18:0] req_addr;
    logic [3:0]  req_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        done;
    logic        err;
    logic [18:0] avm_addr;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_burstcount;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    int checks = 0;
    int errors = 0;
    int accepts;

    int wv_t[7]   = '{1, 1, 0, 1, 1, 1, 1};
    int wait_t[7] = '{1, 0, 0, 1, 0, 1, 0};

    memory_burst_master dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_addr          (req_addr),
        .req_len           (req_len),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .wr_data           (wr_data),
        .rd_valid          (rd_valid),
        .rd_data           (rd_data),
        .rd_last           (rd_last),
        .done              (done),
        .err               (err),
        .avm_addr          (avm_addr),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_burstcount    (avm_burstcount),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".req_ready"}, 64'(req_ready), 64'd1);
        chk({tag, ".outs"}, 64'({rd_valid, rd_last, done, err, avm_read, avm_write, wr_ready}), 64'd0);
        chk({tag, ".buses"}, 64'({avm_addr, avm_burstcount}), 64'd0);
        chk({tag, ".data"}, 64'({rd_data, avm_writedata}), 64'd0);
    endtask

    initial begin
        reset_n           = 1'b0;
        req_valid         = 1'b0;
        req_write         = 1'b0;
        req_addr          = '0;
        req_len           = 4'd0;
        wr_valid          = 1'b0;
        wr_data           = '0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = '0;
        avm_readdatavalid = 1'b0;
        cyc();
        cyc();
        #1;
        chk_idle("reset");
        reset_n = 1'b1;
        cyc();

        // 1: read len 4, three waitrequest cycles, four beats with one gap
        req_valid = 1'b1; req_write = 1'b0; req_addr = 19'h00100; req_len = 4'd4;
        avm_waitrequest = 1'b1;
        #1 chk("t1.req_ready", 64'(req_ready), 64'd1);
        cyc();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            avm_waitrequest = (i < 3);
            #1;
            chk("t1.avm_read", 64'(avm_read), 64'd1);
            chk("t1.burstcount", 64'(avm_burstcount), 64'd4);
            chk("t1.addr", 64'(avm_addr), 64'h00100);
            chk("t1.req_ready_busy", 64'(req_ready), 64'd0);
            cyc();
        end
        avm_waitrequest = 1'b0;
        #1 chk("t1.read_dropped", 64'(avm_read), 64'd0);
        for (int i = 0; i < 4; i++) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = 32'hA0 + 32'(i);
            #1;
            chk("t1.rd_valid", 64'(rd_valid), 64'd1);
            chk("t1.rd_data", 64'(rd_data), 64'hA0 + 64'(i));
            chk("t1.rd_last", 64'(rd_last), 64'(i == 3));
            chk("t1.no_done", 64'(done), 64'd0);
            cyc();
            if (i == 1) begin
                avm_readdatavalid = 1'b0;
                #1;
                chk("t1.gap_rd_valid", 64'(rd_valid), 64'd0);
                cyc();
            end
        end
        avm_readdatavalid = 1'b0;
        #1;
        chk("t1.done", 64'(done), 64'd1);
        chk("t1.done_ready", 64'(req_ready), 64'd1);
        cyc();
        #1 chk("t1.done_once", 64'(done), 64'd0);

        // 2: write len 3 at top address, wr_valid gap and toggling waitrequest
        req_valid = 1'b1; req_write = 1'b1; req_addr = 19'h7FFFF; req_len = 4'd3;
        cyc();
        req_valid = 1'b0;
        accepts = 0;
        for (int c = 0; c < 7; c++) begin
            wr_valid = wv_t[c][0];
            avm_waitrequest = wait_t[c][0];
            wr_data = 32'hD000_0000 + 32'(c);
            #1;
            chk("t2.avm_write", 64'(avm_write), 64'(wv_t[c]));
            chk("t2.wr_ready", 64'(wr_ready), 64'(wv_t[c] == 1 && wait_t[c] == 0));
            chk("t2.addr", 64'(avm_addr), 64'h7FFFF);
            chk("t2.burstcount", 64'(avm_burstcount), 64'd3);
            chk("t2.writedata", 64'(avm_writedata), (wv_t[c] == 1) ? 64'hD000_0000 + 64'(c) : 64'd0);
            chk("t2.no_done", 64'(done), 64'd0);
            if (wr_ready) accepts++;
            cyc();
        end
        wr_valid = 1'b0;
        avm_waitrequest = 1'b0;
        #1;
        chk("t2.accepts", 64'(accepts), 64'd3);
        chk("t2.done", 64'(done), 64'd1);
        chk("t2.idle_write", 64'(avm_write), 64'd0);
        cyc();
        #1 chk("t2.done_once", 64'(done), 64'd0);

        // 3a: req_len 0 becomes a single-beat burst
        req_valid = 1'b1; req_write = 1'b0; req_addr = 19'h00042; req_len = 4'd0;
        cyc();
        req_valid = 1'b0;
        #1 chk("t3.len0_burstcount", 64'(avm_burstcount), 64'd1);
        cyc();
        avm_readdatavalid = 1'b1; avm_readdata = 32'h5555_AAAA;
        #1;
        chk("t3.len0_data", 64'(rd_data), 64'h5555_AAAA);
        chk("t3.len0_last", 64'(rd_last), 64'd1);
        cyc();
        avm_readdatavalid = 1'b0;
        #1 chk("t3.len0_done", 64'(done), 64'd1);
        cyc();

        // 3b: req_len 12 clamps to 8 beats
        req_valid = 1'b1; req_write = 1'b1; req_addr = 19'h01000; req_len = 4'd12;
        cyc();
        req_valid = 1'b0;
        wr_valid = 1'b1;
        #1 chk("t3.len12_burstcount", 64'(avm_burstcount), 64'd8);
        for (int i = 0; i < 8; i++) begin
            wr_data = 32'hC0 + 32'(i);
            #1;
            chk("t3.len12_wr_ready", 64'(wr_ready), 64'd1);
            chk("t3.len12_no_done", 64'(done), 64'd0);
            cyc();
        end
        wr_valid = 1'b0;

        // 4: new request held during the done cycle is accepted at once
        req_valid = 1'b1; req_write = 1'b0; req_addr = 19'h12345; req_len = 4'd2;
        #1;
        chk("t4.done", 64'(done), 64'd1);
        chk("t4.ready_in_done", 64'(req_ready), 64'd1);
        cyc();
        req_valid = 1'b0;
        #1;
        chk("t4.b2b_read", 64'(avm_read), 64'd1);
        chk("t4.b2b_addr", 64'(avm_addr), 64'h12345);
        chk("t4.done_cleared", 64'(done), 64'd0);
        cyc();

        // 5: reset during the final read beat abandons the burst without done
        avm_readdatavalid = 1'b1; avm_readdata = 32'hB0;
        #1 chk("t5.beat1", 64'(rd_valid), 64'd1);
        cyc();
        avm_readdata = 32'hB1;
        reset_n = 1'b0;
        #1 chk("t5.beat2_last", 64'(rd_last), 64'd1);
        cyc();
        reset_n = 1'b1;
        avm_readdatavalid = 1'b0;
        #1 chk_idle("t5.after_reset");
        cyc();
        #1 chk("t5.no_late_done", 64'(done), 64'd0);

        // 6: read with no returned data
        req_valid = 1'b1; req_write = 1'b0; req_addr = 19'h00200; req_len = 4'd1;
        cyc();
        req_valid = 1'b0;
        cyc();
`ifdef MEM_MASTER_TIMEOUT_EN
        repeat (254) cyc();
        #1;
        chk("t6.err_early", 64'(err), 64'd0);
        chk("t6.still_busy", 64'(req_ready), 64'd0);
        cyc();
        avm_readdatavalid = 1'b1; avm_readdata = 32'hDEAD;
        #1;
        chk("t6.err", 64'(err), 64'd1);
        chk("t6.idle", 64'(req_ready), 64'd1);
        chk("t6.no_done", 64'(done), 64'd0);
        chk("t6.late_beat", 64'(rd_valid), 64'd0);
        cyc();
        avm_readdatavalid = 1'b0;
        #1 chk("t6.err_once", 64'(err), 64'd0);
`else
        for (int i = 0; i < 300; i++) begin
            #1 chk("t6.err_never", 64'(err), 64'd0);
            cyc();
        end
        #1 chk("t6.waits", 64'(req_ready), 64'd0);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        #1 chk_idle("t6.final_reset");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
